// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit pipeline memory port onto a 16-bit asynchronous SRAM
//
// Each 32-bit access is split into two 16-bit half-accesses (low half first),
// each held for SRAM_WAIT cycles. The pipeline is frozen (ready=0) until the
// access reaches DONE.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN  read / write request from MEM stage (write wins)
//   address, wdata      byte address and store data, held stable while ready=0
//   rdata               registered load data
//   ready               0 = freeze pipeline, 1 = complete or idle
//   SRAM_DQ             16-bit bidirectional data bus
//   SRAM_ADDR           half-word address
//   SRAM_WE_N           active-low write strobe
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  tied low

module sram_controller #(
    parameter int SRAM_WAIT = 2,
    parameter int MEM_BASE  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

    localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] widx_q, widx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] addr_off;
    logic [16:0] req_widx;
    logic        last_cycle;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_addr_bits;

    // Addresses below MEM_BASE wrap around the 2^17-word space.
    assign addr_off         = address - 32'(MEM_BASE);
    assign req_widx         = addr_off[18:2];
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    assign last_cycle = (cnt_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    state_d = WR_LO;
                    widx_d  = req_widx;
                    wdata_d = wdata;
                end else if (MEM_R_EN) begin
                    state_d = RD_LO;
                    widx_d  = req_widx;
                    wdata_d = wdata;
                end
            end
            RD_LO: begin
                if (last_cycle) begin
                    rdata_d[15:0] = SRAM_DQ;
                    state_d       = RD_HI;
                end
            end
            RD_HI: begin
                if (last_cycle) begin
                    rdata_d[31:16] = SRAM_DQ;
                    state_d        = DONE;
                end
            end
            WR_LO: begin
                if (last_cycle) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                if (last_cycle) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state starts its wait count from zero.
        if (state_d != state_q || state_q == IDLE) begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            widx_q  <= 17'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
        SRAM_ADDR = {widx_q, 1'b0};

        unique case (state_q)
            IDLE: begin
                ready     = !(MEM_R_EN || MEM_W_EN);
                // Present the pending request's low half so the SRAM can start early.
                SRAM_ADDR = {req_widx, 1'b0};
            end
            RD_LO: begin
                SRAM_ADDR = {widx_q, 1'b0};
            end
            RD_HI: begin
                SRAM_ADDR = {widx_q, 1'b1};
            end
            WR_LO: begin
                SRAM_ADDR = {widx_q, 1'b0};
                SRAM_WE_N = 1'b0;
                dq_oe     = 1'b1;
                dq_out    = wdata_q[15:0];
            end
            WR_HI: begin
                SRAM_ADDR = {widx_q, 1'b1};
                SRAM_WE_N = 1'b0;
                dq_oe     = 1'b1;
                dq_out    = wdata_q[31:16];
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign rdata     = rdata_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter SRAM_WAIT, default 2: number of cycles each 16-bit SRAM half-access is held; legal range 1..15.
REQ-002 The block SHALL have parameter MEM_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have these pipeline-side ports:
- MEM_R_EN  input  1  read request from MEM stage
- MEM_W_EN  input  1  write request from MEM stage
- address  input  32  byte address (ALU result)
- wdata  input  32  store data (Val_Rm)
- rdata  output  32  load data, registered
- ready  output  1  low = freeze pipeline; high = access complete or no access pending
REQ-005 The block SHALL have these SRAM-side ports:
- SRAM_DQ  inout  16  data bus
- SRAM_ADDR  output  18  half-word address
- SRAM_WE_N  output  1  active-low write strobe
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied low (always enabled)

Function
REQ-006 The word index SHALL be widx = (address - MEM_BASE)[18:2], 17 bits; out-of-range addresses wrap modulo 2^17 words, with no error flag.
REQ-007 The low half SHALL be at SRAM_ADDR = {widx,1'b0} and the high half at {widx,1'b1}.
REQ-008 The FSM SHALL have states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-009 IDLE: MEM_W_EN=1 -> WR_LO; else MEM_R_EN=1 -> RD_LO; else stay. Write wins when both are asserted.
REQ-010 Each LO/HI state SHALL last exactly SRAM_WAIT cycles, timed by a 4-bit counter that is cleared on every state entry.
REQ-011 The FSM SHALL advance LO -> HI and HI -> DONE when the counter reaches SRAM_WAIT-1.
REQ-012 DONE SHALL last one cycle and then return to IDLE unconditionally; the request seen in IDLE on the next cycle is treated as a new access.
REQ-013 ready SHALL be combinational: 0 in RD_*/WR_*, 0 in IDLE while MEM_R_EN or MEM_W_EN is asserted, and 1 otherwise (including DONE).
REQ-014 Latency: with the request first seen in IDLE at cycle 0, ready SHALL be low for cycles 0..2*SRAM_WAIT and high at cycle 2*SRAM_WAIT+1 (DONE).
REQ-015 The pipeline holds address, wdata and the enables stable while ready=0; the controller SHALL latch address and wdata on leaving IDLE and use only the latched copies until DONE.
REQ-016 In WR_LO/WR_HI, SRAM_DQ SHALL drive wdata_latched[15:0] / [31:16] and SRAM_WE_N SHALL be 0; in all other states SRAM_DQ SHALL be high-Z and SRAM_WE_N SHALL be 1.
REQ-017 SRAM_ADDR SHALL present the LO half-word address in IDLE and *_LO states, and the HI half-word address in *_HI states.
REQ-018 On the last cycle of RD_LO/RD_HI, SRAM_DQ SHALL be sampled into rdata[15:0] / rdata[31:16].
REQ-019 rdata SHALL hold its value until the next read overwrites it; writes SHALL NOT modify rdata.
REQ-020 Enables deasserted mid-access SHALL NOT abort it; the access completes to DONE.

Reset
REQ-021 rst=1 at any clock edge SHALL force state=IDLE, counter=0, rdata=0, latched address and wdata=0, SRAM_WE_N=1 and SRAM_DQ=high-Z, including mid-access.
REQ-022 An interrupted write SHALL leave SRAM contents undefined only for the half being written.
REQ-023 After reset with no request pending, ready SHALL be 1.
REQ-024 The first clock after rst falls SHALL be able to accept a request.

Verification
REQ-025 Write: SRAM_WAIT=2, MEM_W_EN=1, address=1032, wdata=0x12345678 -> SRAM[4]=0x5678, SRAM[5]=0x1234; WE_N low for 4 cycles; ready low for 5 cycles, high on the 6th.
REQ-026 Read-back: MEM_R_EN=1, address=1032 -> rdata=0x12345678 during DONE; ready low for 5 cycles; DQ never driven by the controller.
REQ-027 Simultaneous: MEM_R_EN=MEM_W_EN=1, address=1024, wdata=0xA5A5_0F0F -> write performed (SRAM[0]=0x0F0F, SRAM[1]=0xA5A5); rdata unchanged.
REQ-028 Reset mid-write: rst asserted in cycle 2 of WR_HI -> next cycle state=IDLE, WE_N=1, DQ=Z, rdata=0, ready=1.
REQ-029 Back-to-back: read address=1036 then write address=1040 with no idle gap -> each completes in 2*SRAM_WAIT+1 cycles, plus 1 DONE cycle between them.
REQ-030 Wrap: address=1020 (below MEM_BASE) -> widx=0x1FFFF, SRAM_ADDR=0x3FFFE/0x3FFFF; run with SRAM_WAIT=1 -> ready low for 3 cycles.
